// File: rtl/spi_to_wb_slave.sv
// rtl/spi_to_wb_slave.sv - SPI mode-0 slave that turns write/read frames into Wishbone cycles
//
// Ports:
//   wb_clk_i, wb_rst_i      sole clock, synchronous active-high reset
//   sck_i, ss_n_i, mosi_i   asynchronous SPI inputs (2-FF synchronized)
//   miso_o, miso_oe         serial data out and its output enable
//   wb_adr_o .. wb_err_i    8-bit Wishbone master port (classic cycle)
//   busy_o                  frame active or Wishbone cycle still open
//   err_o                   sticky error, cleared at the next frame start
module spi_to_wb_slave #(
  parameter int TIMEOUT = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i,
  input  logic       wb_err_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  state_t      state;
  logic [2:0]  sck_q;       // [1] synchronized, [2] previous sample
  logic [2:0]  ss_q;
  logic [1:0]  mosi_q;
  logic        armed;       // a high ss_n has been seen since reset
  logic        is_read;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [6:0]  tx_shift;    // remaining bits after the one on miso_o
  logic [7:0]  addr;        // address of the next Wishbone access
  logic [7:0]  rd_buf;
  logic        rd_valid;    // rd_buf holds the prefetch for the next byte
  logic        rd_discard;  // open read was overrun, drop its result
  logic [15:0] to_cnt;

  logic       sck_rise, sck_fall, ss_fall, ss_rise;
  logic       byte_done, cmd_ok, addr_rd, wr_byte, rd_load, rd_fetch;
  logic       wb_timeout, wb_done, wb_bad, err_set;
  logic [7:0] rx_byte, load_byte, fetch_adr;

  always_comb begin
    sck_rise   = sck_q[1] & ~sck_q[2];
    sck_fall   = ~sck_q[1] & sck_q[2];
    // A frame only starts after ss_n was seen high, so a reset inside a
    // frame ignores the rest of it.
    ss_fall    = armed & ss_q[2] & ~ss_q[1];
    ss_rise    = ss_q[1] & ~ss_q[2];
    rx_byte    = {rx_shift, mosi_q[1]};
    byte_done  = (state != S_IDLE) & ~ss_rise & sck_rise & (bit_cnt == 3'd7);
    cmd_ok     = (rx_byte == 8'h02) | (rx_byte == 8'h03);
    addr_rd    = byte_done & (state == S_ADDR) & is_read;
    wr_byte    = byte_done & (state == S_DATA) & ~is_read;
    // Last SCK fall of a dummy/data byte: bit_cnt has wrapped back to 0.
    rd_load    = (state == S_DATA) & is_read & ~ss_rise & sck_fall & (bit_cnt == 3'd0);
    rd_fetch   = addr_rd | rd_load;
    fetch_adr  = addr_rd ? rx_byte : addr;
    wb_timeout = (to_cnt == TO_LAST);
    wb_done    = wb_cyc_o & (wb_ack_i | wb_err_i | wb_timeout);
    wb_bad     = wb_cyc_o & (wb_err_i | (~wb_ack_i & wb_timeout));
    load_byte  = (~wb_cyc_o & rd_valid) ? rd_buf : 8'hFF;
    err_set    = wb_bad
               | (byte_done & (state == S_CMD) & ~cmd_ok)
               | ((rd_fetch | wr_byte) & wb_cyc_o);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      sck_q      <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      armed      <= 1'b0;
      is_read    <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      addr       <= '0;
      rd_buf     <= '0;
      rd_valid   <= 1'b0;
      rd_discard <= 1'b0;
      to_cnt     <= '0;
      miso_o     <= 1'b0;
      miso_oe    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      sck_q   <= {sck_q[1:0], sck_i};
      ss_q    <= {ss_q[1:0], ss_n_i};
      mosi_q  <= {mosi_q[0], mosi_i};
      armed   <= armed | ss_q[1];
      miso_oe <= armed & ~ss_q[1];

      // Wishbone cycle termination
      if (wb_cyc_o) begin
        if (wb_done) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          to_cnt   <= '0;
          if (!wb_we_o) begin
            rd_buf   <= wb_bad ? 8'hFF : wb_dat_i;
            rd_valid <= ~rd_discard;
          end
          rd_discard <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end

      // Frame FSM
      if (ss_rise) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (state == S_IDLE) begin
        if (ss_fall) begin
          state    <= S_CMD;
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end else if (sck_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            S_CMD: begin
              if (cmd_ok) begin
                is_read <= rx_byte[0];
                state   <= S_ADDR;
              end else begin
                state <= S_IGNORE;
              end
            end
            S_ADDR: begin
              addr  <= rx_byte;
              state <= is_read ? S_DUMMY : S_DATA;
            end
            S_DUMMY: state <= S_DATA;
            default: ;
          endcase
        end
      end

      // Read prefetch; an overrun skips the address and poisons the open read
      if (rd_fetch) begin
        rd_valid <= 1'b0;
        if (wb_cyc_o) begin
          rd_discard <= ~wb_done;
        end else begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b0;
          wb_adr_o <= fetch_adr;
        end
        addr <= fetch_adr + 8'd1;
      end

      if (wr_byte) begin
        if (!wb_cyc_o) begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= addr;
          wb_dat_o <= rx_byte;
        end
        addr <= addr + 8'd1;
      end

      // MISO: driven only for read data bytes, MSB first, changes on SCK fall
      if (ss_rise || state != S_DATA || !is_read) begin
        miso_o <= 1'b0;
      end else if (rd_load) begin
        tx_shift <= load_byte[6:0];
        miso_o   <= load_byte[7];
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[5:0], 1'b0};
        miso_o   <= tx_shift[6];
      end

      err_o  <= err_set | (err_o & ~ss_fall);
      busy_o <= ((state != S_IDLE) & ~ss_rise) | ss_fall | (wb_cyc_o & ~wb_done);
    end
  end

endmodule

// File: tb/tb_spi_to_wb_slave.sv
// tb/tb_spi_to_wb_slave.sv - self-checking bench for spi_to_wb_slave
module tb_spi_to_wb_slave;

  localparam int TIMEOUT = 255;
  localparam int H       = 20;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       sck_i, ss_n_i, mosi_i;
  logic       miso_o, miso_oe;
  logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic       wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic       busy_o, err_o;

  always #5 wb_clk_i = ~wb_clk_i;

  spi_to_wb_slave #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe(miso_oe),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave memory and observed write log
  logic [7:0] mem [256];
  logic [7:0] log_adr[$], log_dat[$];
  logic [7:0] exp_adr[$], exp_dat[$];
  logic       never_ack = 1'b0;
  int         lat = 0;

  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (wb_ack_i || wb_err_i) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !never_ack) begin
        if (lat > 0) begin
          lat--;
        end else begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            mem[wb_adr_o] = wb_dat_o;
            log_adr.push_back(wb_adr_o);
            log_dat.push_back(wb_dat_o);
          end else begin
            wb_dat_i = mem[wb_adr_o];
          end
          lat = $urandom_range(0, 3);
        end
      end
    end
  end

  // Cycle monitor: starts, length of the last cycle, protocol violations
  int         cyc_starts = 0, cur_len = 0, last_len = 0, viol = 0;
  logic       prev_cyc = 1'b0;
  logic [7:0] s_adr, s_dat;
  logic       s_we;

  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (wb_cyc_o !== wb_stb_o) viol++;
      if (wb_cyc_o && !prev_cyc) begin
        cyc_starts++;
        cur_len = 1;
        s_adr = wb_adr_o; s_dat = wb_dat_o; s_we = wb_we_o;
      end else if (wb_cyc_o) begin
        cur_len++;
        if (wb_adr_o !== s_adr || wb_we_o !== s_we || (s_we && wb_dat_o !== s_dat)) viol++;
      end else if (prev_cyc) begin
        last_len = cur_len;
      end
      prev_cyc = wb_cyc_o;
    end
  end

  // SPI master
  logic [7:0] tx_q[$], rx_q[$], data_q[$];

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = tx[7-i];
      repeat (H) @(negedge wb_clk_i);
      rx = {rx[6:0], miso_o};
      sck_i = 1'b1;
      repeat (H) @(negedge wb_clk_i);
      sck_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (4) @(negedge wb_clk_i);
    while (busy_o && k < 3000) begin
      @(negedge wb_clk_i);
      k++;
    end
    check("busy_idle", busy_o, 1'b0);
  endtask

  task automatic frame_begin();
    ss_n_i = 1'b0;
    repeat (H) @(negedge wb_clk_i);
    check("miso_oe_frame", miso_oe, 1'b1);
  endtask

  task automatic frame_bytes();
    logic [7:0] b;
    rx_q.delete();
    foreach (tx_q[i]) begin
      spi_xfer(tx_q[i], 8, b);
      rx_q.push_back(b);
    end
  endtask

  task automatic frame_end();
    repeat (H) @(negedge wb_clk_i);
    ss_n_i = 1'b1;
    wait_idle();
    check("miso_oe_idle", miso_oe, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, log_adr.size(), exp_adr.size());
    for (int i = 0; i < exp_adr.size() && i < log_adr.size(); i++) begin
      check({tag, "_adr"}, log_adr[i], exp_adr[i]);
      check({tag, "_dat"}, log_dat[i], exp_dat[i]);
    end
    log_adr.delete(); log_dat.delete();
    exp_adr.delete(); exp_dat.delete();
  endtask

  // Data bytes in data_q go to consecutive addresses from a, wrapping at 256
  task automatic write_frame(input string tag, input logic [7:0] a);
    tx_q = '{8'h02, a};
    foreach (data_q[k]) begin
      tx_q.push_back(data_q[k]);
      exp_adr.push_back(8'((int'(a) + k) % 256));
      exp_dat.push_back(data_q[k]);
    end
    frame_begin(); frame_bytes(); frame_end();
    check_writes(tag);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  // Master sees 0x00 during cmd/addr/dummy, then mem[a+k] (or 0xFF on failed fetch)
  task automatic read_frame(input string tag, input logic [7:0] a, input int n, input logic fail);
    logic [7:0] exp_rx[$];
    exp_rx = '{8'h00, 8'h00, 8'h00};
    tx_q = '{8'h03, a, 8'h00};
    for (int k = 0; k < n; k++) begin
      tx_q.push_back(8'($urandom));
      exp_rx.push_back(fail ? 8'hFF : mem[8'((int'(a) + k) % 256)]);
    end
    frame_begin(); frame_bytes(); frame_end();
    for (int k = 0; k < exp_rx.size(); k++)
      check($sformatf("%s_miso%0d", tag, k), rx_q[k], exp_rx[k]);
    check({tag, "_err"}, err_o, fail);
  endtask

  initial begin
    int cs;
    logic [7:0] b;
    wb_rst_i = 1'b1; ss_n_i = 1'b1; sck_i = 1'b0; mosi_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (5) @(negedge wb_clk_i);
    check("reset_outputs", {miso_o, miso_oe, wb_adr_o, wb_dat_o, wb_we_o,
                            wb_cyc_o, wb_stb_o, busy_o, err_o}, 0);
    wb_rst_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);

    // Directed write
    data_q = '{8'hAA, 8'h55};
    write_frame("wr_dir", 8'h10);

    // Directed read across the address wrap
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    read_frame("rd_wrap", 8'hFE, 3, 1'b0);

    // Illegal command, then err_o clears on the next frame start
    cs = cyc_starts;
    tx_q = '{8'h7E, 8'h00, 8'h00};
    frame_begin(); frame_bytes(); frame_end();
    check("badcmd_nocyc", cyc_starts, cs);
    check("badcmd_err", err_o, 1'b1);
    ss_n_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    check("badcmd_errclr", err_o, 1'b0);
    tx_q = '{8'h02, 8'h50, 8'h12};
    exp_adr = '{8'h50}; exp_dat = '{8'h12};
    frame_bytes(); frame_end();
    check_writes("after_bad");

    // Read with no acknowledge: timeout, 0xFF on miso, err_o set
    never_ack = 1'b1;
    read_frame("rd_to", 8'h20, 1, 1'b1);
    check("timeout_len", last_len, TIMEOUT);
    never_ack = 1'b0;

    // ss_n rises after 4 bits of a data byte
    cs = cyc_starts;
    tx_q = '{8'h02, 8'h40};
    frame_begin(); frame_bytes();
    spi_xfer(8'hC3, 4, b);
    frame_end();
    check("partial_nocyc", cyc_starts, cs);
    check_writes("partial");
    data_q = '{8'h99};
    write_frame("after_partial", 8'h41);

    // Reset during an open write cycle
    never_ack = 1'b1;
    cs = cyc_starts;
    frame_begin();
    fork
      begin
        logic [7:0] r;
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'h30, 8, r);
        spi_xfer(8'h5A, 8, r);
        spi_xfer(8'h77, 8, r);
      end
      begin
        int k = 0;
        while (!wb_cyc_o && k < 2000) begin
          @(negedge wb_clk_i);
          k++;
        end
        check("rst_cyc_open", wb_cyc_o, 1'b1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("rst_outputs", {miso_o, miso_oe, wb_adr_o, wb_dat_o, wb_we_o,
                              wb_cyc_o, wb_stb_o, busy_o, err_o}, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
      end
    join
    repeat (H) @(negedge wb_clk_i);
    ss_n_i = 1'b1;
    wait_idle();
    never_ack = 1'b0;
    check("rst_ignored", cyc_starts, cs + 1);
    check_writes("rst");
    data_q = '{8'h66};
    write_frame("after_rst", 8'h31);

    // Randomized frames against the memory model
    for (int it = 0; it < 8; it++) begin
      logic [7:0] a;
      int n;
      a = 8'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        data_q.delete();
        for (int k = 0; k < n; k++) data_q.push_back(8'($urandom));
        write_frame($sformatf("rnd_wr%0d", it), a);
      end else begin
        read_frame($sformatf("rnd_rd%0d", it), a, n, 1'b0);
      end
    end

    check("wb_stable", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
